// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM states, word-length encoding and
// the per-frame configuration snapshot.
package uart_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    typedef enum logic [1:0] {
        BITS_5 = 2'b00,
        BITS_6 = 2'b01,
        BITS_7 = 2'b10,
        BITS_8 = 2'b11
    } uart_bits_e;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        uart_bits_e       bits;
        logic             parity_en;
        logic             stop_bits;
    } uart_tx_cfg_t;

    // Index of the last data bit for a given word length (N-1 = 4 + bits).
    function automatic logic [2:0] last_bit_idx(input uart_bits_e bits);
        return 3'd4 + {1'b0, bits};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..div while enabled and emits a one-cycle tick
// at count==div; cleared synchronously when a new frame is accepted.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    assign tick_o = en_i && (count_q == div_i);

    // Next count: wrap on tick, hold at zero while idle or on frame start.
    always_comb begin
        count_d = count_q;
        if (clr_i || !en_i || tick_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional even parity,
// 1 or 2 stop bits, bit period set by a runtime divider.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_en_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [1:0]        cfg_bits_i,
    input  logic              cfg_parity_en_i,
    input  logic              cfg_stop_bits_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    uart_tx_state_e    state_q;
    uart_tx_cfg_t      cfg_q;
    logic [DATA_W-1:0] shift_q;
    logic [2:0]        bit_cnt_q;
    logic              par_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              tick_s;
    logic              start_s;

    // Gating with rst_i keeps ready low while reset is held.
    assign ready_o = (state_q == IDLE) && cfg_en_i && !rst_i;
    assign start_s = valid_i && ready_o;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (busy_q),
        .clr_i  (start_s),
        .div_i  (cfg_q.div),
        .tick_o (tick_s)
    );

    // Frame sequencer; tx/busy/done are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= 3'd0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        cfg_q.div       <= cfg_div_i;
                        cfg_q.bits      <= uart_bits_e'(cfg_bits_i);
                        cfg_q.parity_en <= cfg_parity_en_i;
                        cfg_q.stop_bits <= cfg_stop_bits_i;
                        shift_q         <= data_i;
                        bit_cnt_q       <= 3'd0;
                        par_q           <= 1'b0;
                        tx_q            <= 1'b0;
                        busy_q          <= 1'b1;
                        state_q         <= START;
                    end else begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        par_q   <= par_q ^ shift_q[0];
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == last_bit_idx(cfg_q.bits)) begin
                            bit_cnt_q <= 3'd0;
                            if (cfg_q.parity_en) begin
                                tx_q    <= par_q ^ shift_q[0];
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (cfg_q.stop_bits && (bit_cnt_q == 3'd0)) begin
                            bit_cnt_q <= 3'd1;
                        end else begin
                            bit_cnt_q <= 3'd0;
                            tx_q      <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
